move_tick_scheduler: RTL

//  Frame sequencer for the game-logic core: divides clk into movement ticks and, once per tick,

---
 rtl/move_tick_scheduler_pkg.sv | 38 +++
 rtl/move_tick_scheduler_if.sv | 22 ++
 rtl/move_tick_scheduler_tick_divider.sv | 45 ++++
 rtl/move_tick_scheduler.sv | 178 +++++++++++++++++
 4 files changed

// File: rtl/move_tick_scheduler_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module  : move_tick_scheduler_pkg                                          |
// | Brief   : Shared entity indices, maze tile codes and scheduler FSM states. |
// | Revision: 1.0  initial release                                             |
// +----------------------------------------------------------------------------+
package move_tick_scheduler_pkg;

    // Mover slot indices; the scheduler visits them in this order every frame.
    typedef enum int {
        ENT_PACMAN = 0,
        ENT_BLINKY = 1,
        ENT_PINKY  = 2,
        ENT_INKY   = 3,
        ENT_CLYDE  = 4
    } ent_e;

    localparam int ENT_COUNT = ENT_CLYDE + 1;

    // Maze map ROM tile codes.
    typedef enum logic [1:0] {
        TILE_EMPTY  = 2'd0,
        TILE_WALL   = 2'd1,
        TILE_PELLET = 2'd2,
        TILE_POWER  = 2'd3
    } tile_e;

    // Frame sequencing states.
    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_ISSUE  = 3'd1,
        ST_WAIT   = 3'd2,
        ST_DECIDE = 3'd3,
        ST_DONE   = 3'd4
    } sched_state_e;

endpackage
`default_nettype wire

// File: rtl/move_tick_scheduler_if.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module  : move_tick_scheduler_if                                           |
// | Brief   : Maze map ROM read bus between the scheduler and the map ROM.     |
// | Revision: 1.0  initial release                                             |
// +----------------------------------------------------------------------------+
interface move_tick_scheduler_if #(
    parameter int IDX_X_W = 7,
    parameter int IDX_Y_W = 6
);
    logic               map_rd;
    logic [IDX_X_W-1:0] map_x;
    logic [IDX_Y_W-1:0] map_y;
    logic [1:0]         map_tile;

    // Scheduler side: drives the address and strobe, receives tile data.
    modport master (output map_rd, output map_x, output map_y, input map_tile);

    // ROM side.
    modport slave  (input map_rd, input map_x, input map_y, output map_tile);
endinterface
`default_nettype wire

// File: rtl/move_tick_scheduler_tick_divider.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module  : move_tick_scheduler_tick_divider                                 |
// | Brief   : Divides clk into a one-cycle movement tick every TICK_DIV cycles.|
// | Revision: 1.0  initial release                                             |
// +----------------------------------------------------------------------------+
module move_tick_scheduler_tick_divider #(
    parameter int TICK_DIV = 1_000_000
) (
    input  logic clk,
    input  logic rst,
    input  logic en,
    output logic tick
);
    localparam int              CNT_W    = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TICK_DIV - 1);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    // Next count: held at zero while the game is stopped, wraps with a tick pulse.
    always_comb begin
        cnt_d = cnt_q;
        tick  = 1'b0;
        if (!en) begin
            cnt_d = '0;
        end else if (cnt_q == CNT_LAST) begin
            cnt_d = '0;
            tick  = 1'b1;
        end else begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    // Counter register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule
`default_nettype wire

// File: rtl/move_tick_scheduler.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module  : move_tick_scheduler                                              |
// | Brief   : Per-tick frame sequencer arbitrating the maze ROM among movers   |
// |           in fixed order and issuing commit / blocked pulses.              |
// | Revision: 1.0  initial release                                             |
// +----------------------------------------------------------------------------+
module move_tick_scheduler
    import move_tick_scheduler_pkg::*;
#(
    parameter int TICK_DIV = 1_000_000,
    parameter int N_ENT    = ENT_COUNT,
    parameter int IDX_X_W  = 7,
    parameter int IDX_Y_W  = 6,
    parameter int ROM_LAT  = 1
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       en,
    input  logic                       freeze,
    input  logic [N_ENT-1:0]           req_valid,
    input  logic [N_ENT*IDX_X_W-1:0]   req_x,
    input  logic [N_ENT*IDX_Y_W-1:0]   req_y,
    move_tick_scheduler_if.master      map_bus,
    output logic [N_ENT-1:0]           step_en,
    output logic [N_ENT-1:0]           step_blocked,
    output logic                       frame_done,
    output logic                       busy,
    output logic                       tick_overrun
);
    localparam int               SLOT_W    = (N_ENT > 1) ? $clog2(N_ENT) : 1;
    localparam logic [SLOT_W-1:0] LAST_SLOT = SLOT_W'(N_ENT - 1);
    localparam logic [1:0]        LAT_LAST  = 2'(ROM_LAT - 1);

    logic tick;

    sched_state_e       state_q,   state_d;
    logic [SLOT_W-1:0]  slot_q,    slot_d;
    logic [1:0]         wait_q,    wait_d;
    logic [1:0]         tile_q,    tile_d;
    logic [IDX_X_W-1:0] map_x_q,   map_x_d;
    logic [IDX_Y_W-1:0] map_y_q,   map_y_d;
    logic               abort_q,   abort_d;
    logic               overrun_q, overrun_d;

    logic               map_rd_w;
    logic [IDX_X_W-1:0] map_x_w;
    logic [IDX_Y_W-1:0] map_y_w;

    logic [IDX_X_W-1:0] req_x_arr [N_ENT];
    logic [IDX_Y_W-1:0] req_y_arr [N_ENT];

    move_tick_scheduler_tick_divider #(
        .TICK_DIV (TICK_DIV)
    ) u_tick_divider (
        .clk  (clk),
        .rst  (rst),
        .en   (en),
        .tick (tick)
    );

    // Split the packed candidate buses into one entry per mover.
    for (genvar gi = 0; gi < N_ENT; gi++) begin : g_unpack
        assign req_x_arr[gi] = req_x[gi*IDX_X_W +: IDX_X_W];
        assign req_y_arr[gi] = req_y[gi*IDX_Y_W +: IDX_Y_W];
    end

    // Next-state and output decode for the frame sequencer.
    always_comb begin
        state_d      = state_q;
        slot_d       = slot_q;
        wait_d       = wait_q;
        tile_d       = tile_q;
        map_x_d      = map_x_q;
        map_y_d      = map_y_q;
        abort_d      = abort_q;
        overrun_d    = overrun_q | (tick & (state_q != ST_IDLE));
        map_rd_w     = 1'b0;
        map_x_w      = map_x_q;
        map_y_w      = map_y_q;
        step_en      = '0;
        step_blocked = '0;
        frame_done   = 1'b0;
        busy         = (state_q != ST_IDLE);

        // A freeze seen at any point inside a frame cuts it short after the current slot.
        if (freeze && (state_q != ST_IDLE) && (state_q != ST_DONE)) begin
            abort_d = 1'b1;
        end

        case (state_q)
            ST_IDLE: begin
                if (tick && !freeze) begin
                    state_d = ST_ISSUE;
                    slot_d  = SLOT_W'(ENT_PACMAN);
                end
            end
            ST_ISSUE: begin
                if (abort_q) begin
                    state_d = ST_DONE;
                end else if (req_valid[slot_q]) begin
                    // Address goes out this cycle and is held until the slot decides.
                    map_rd_w = 1'b1;
                    map_x_w  = req_x_arr[slot_q];
                    map_y_w  = req_y_arr[slot_q];
                    map_x_d  = req_x_arr[slot_q];
                    map_y_d  = req_y_arr[slot_q];
                    wait_d   = '0;
                    state_d  = ST_WAIT;
                end else if (slot_q == LAST_SLOT) begin
                    state_d = ST_DONE;
                end else begin
                    slot_d = slot_q + 1'b1;
                end
            end
            ST_WAIT: begin
                // Tile data is valid in the last wait cycle; capture it for the decision.
                if (wait_q == LAT_LAST) begin
                    tile_d  = map_bus.map_tile;
                    state_d = ST_DECIDE;
                end else begin
                    wait_d = wait_q + 1'b1;
                end
            end
            ST_DECIDE: begin
                if (tile_q == TILE_WALL) begin
                    step_blocked[slot_q] = 1'b1;
                end else begin
                    step_en[slot_q] = 1'b1;
                end
                if (abort_q || freeze || (slot_q == LAST_SLOT)) begin
                    state_d = ST_DONE;
                end else begin
                    slot_d  = slot_q + 1'b1;
                    state_d = ST_ISSUE;
                end
            end
            ST_DONE: begin
                frame_done = 1'b1;
                abort_d    = 1'b0;
                state_d    = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    assign map_bus.map_rd = map_rd_w;
    assign map_bus.map_x  = map_x_w;
    assign map_bus.map_y  = map_y_w;
    assign tick_overrun   = overrun_q;

    // Sequencer registers; reset aborts any frame in flight without pulses.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            slot_q    <= '0;
            wait_q    <= '0;
            tile_q    <= '0;
            map_x_q   <= '0;
            map_y_q   <= '0;
            abort_q   <= 1'b0;
            overrun_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            slot_q    <= slot_d;
            wait_q    <= wait_d;
            tile_q    <= tile_d;
            map_x_q   <= map_x_d;
            map_y_q   <= map_y_d;
            abort_q   <= abort_d;
            overrun_q <= overrun_d;
        end
    end

endmodule
`default_nettype wire
